// File: rtl/stream_src_gen.sv
// Packet source for the FT600 endpoint buffers: fixed-length packets of
// incrementing words, with a persistent sequence counter per endpoint.
module stream_src_gen #(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] SEED_INC = 32'd1
) (
    input  logic             fifoClk,
    input  logic             fifoRst,
    input  logic             start,
    input  logic [2:0]       ep_sel,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             abort,
    input  logic             clr_seq,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [31:0]      tx_data,
    output logic [3:0]       tx_be,
    output logic             tx_last,
    output logic [2:0]       tx_ep_num,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

    state_t           state;
    logic [2:0]       ep;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0]   words_left;
    logic [3:0]       last_be;
    logic             abort_q;
    logic [3:0][31:0] seq;

    logic [1:0]       idx;
    logic [LEN_W:0]   words_calc;
    logic [3:0]       be_calc;
    logic [31:0]      next_word;
    logic             hs;
    logic             start_ok;

    // endpoints 1..4 map onto counter slots 0..3 (3'b100 wraps to 2'b11)
    assign idx        = ep[1:0] - 2'd1;
    assign words_calc = ({1'b0, len} + (LEN_W+1)'(3)) >> 2;
    assign next_word  = tx_data + SEED_INC;
    assign hs         = tx_valid & tx_ready;
    assign start_ok   = (pkt_len != '0) && (ep_sel >= 3'd1) && (ep_sel <= 3'd4);

    always_comb begin
        be_calc = 4'b1111;
        case (len[1:0])
            2'b01:   be_calc = 4'b0001;
            2'b10:   be_calc = 4'b0011;
            2'b11:   be_calc = 4'b0111;
            default: be_calc = 4'b1111;
        endcase
    end

    always_ff @(posedge fifoClk or posedge fifoRst) begin
        if (fifoRst) begin
            state      <= IDLE;
            ep         <= '0;
            len        <= '0;
            words_left <= '0;
            last_be    <= '0;
            abort_q    <= 1'b0;
            seq        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_be      <= '0;
            tx_last    <= 1'b0;
            tx_ep_num  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // clear lands before LOAD reads the counter, so a
                    // simultaneous start begins at zero
                    if (clr_seq) seq <= '0;
                    if (start) begin
                        if (start_ok) begin
                            ep    <= ep_sel;
                            len   <= pkt_len;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    words_left <= words_calc;
                    last_be    <= be_calc;
                    abort_q    <= 1'b0;
                    tx_valid   <= 1'b1;
                    tx_data    <= seq[idx];
                    tx_ep_num  <= ep;
                    tx_last    <= (words_calc == (LEN_W+1)'(1));
                    tx_be      <= (words_calc == (LEN_W+1)'(1)) ? be_calc : 4'b1111;
                    state      <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        seq[idx]   <= next_word;
                        words_left <= words_left - (LEN_W+1)'(1);
                        if (tx_last || abort || abort_q) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            tx_be    <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            aborted  <= ~tx_last;
                            state    <= FIN;
                        end else begin
                            tx_data <= next_word;
                            tx_last <= (words_left == (LEN_W+1)'(2));
                            tx_be   <= (words_left == (LEN_W+1)'(2)) ? last_be : 4'b1111;
                        end
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_src_gen.sv
// Directed bench for stream_src_gen: packet table plus error, wrap and reset sequences.
module tb_stream_src_gen;
    logic        fifoClk = 1'b0;
    logic        fifoRst;
    logic        start, abort, clr_seq, tx_ready;
    logic [2:0]  ep_sel;
    logic [15:0] pkt_len;

    logic        v1, l1, b1, dn1, ab1, e1, v2, l2, b2, dn2, ab2, e2;
    logic [31:0] d1, d2;
    logic [3:0]  be1, be2;
    logic [2:0]  ep1, ep2;

    int passed = 0;
    int total  = 0;

    always #5 fifoClk = ~fifoClk;

    stream_src_gen #(.LEN_W(16), .SEED_INC(32'd1)) dut (
        .fifoClk(fifoClk), .fifoRst(fifoRst), .start(start), .ep_sel(ep_sel),
        .pkt_len(pkt_len), .abort(abort), .clr_seq(clr_seq), .tx_ready(tx_ready),
        .tx_valid(v1), .tx_data(d1), .tx_be(be1), .tx_last(l1), .tx_ep_num(ep1),
        .busy(b1), .done(dn1), .aborted(ab1), .err(e1));

    // large increment exposes the 32-bit wrap within a few words
    stream_src_gen #(.LEN_W(16), .SEED_INC(32'h7FFFFFFF)) dut_w (
        .fifoClk(fifoClk), .fifoRst(fifoRst), .start(start), .ep_sel(ep_sel),
        .pkt_len(pkt_len), .abort(abort), .clr_seq(clr_seq), .tx_ready(tx_ready),
        .tx_valid(v2), .tx_data(d2), .tx_be(be2), .tx_last(l2), .tx_ep_num(ep2),
        .busy(b2), .done(dn2), .aborted(ab2), .err(e2));

    typedef struct {
        logic [2:0]  ep;
        logic [15:0] len;
        logic        clr;
        logic [15:0] mask;
        int          abort_w;
        logic        sel;
        logic [31:0] first;
        logic [31:0] inc;
        int          n;
        logic [3:0]  lbe;
        logic        exp_ab;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic run(input vec_t v);
        logic        cv, cl, cdn, cab, cb, stalled, rdy;
        logic [31:0] cd, hd, ed;
        logic [3:0]  cbe, hbe, ebe;
        logic        hl, el;
        logic [2:0]  cep;
        int          cyc, k, nt;
        nt = (int'(v.len) + 3) / 4;
        start = 1'b1; ep_sel = v.ep; pkt_len = v.len; clr_seq = v.clr; tx_ready = 1'b0;
        @(negedge fifoClk);
        start = 1'b0; clr_seq = 1'b0; ep_sel = 3'd0; pkt_len = 16'd0;
        cv = v.sel ? v2 : v1; cb = v.sel ? b2 : b1;
        chk("load_cycle", !cv && cb, {62'd0, cv, cb}, 64'd1);
        @(negedge fifoClk);
        cv = v.sel ? v2 : v1;
        chk("latency_n2", cv, {63'd0, cv}, 64'd1);
        cyc = 0; k = 0; stalled = 1'b0; hd = '0; hbe = '0; hl = 1'b0;
        while (k < v.n && cyc < 200) begin
            cv = v.sel ? v2 : v1; cd = v.sel ? d2 : d1; cbe = v.sel ? be2 : be1;
            cl = v.sel ? l2 : l1; cep = v.sel ? ep2 : ep1;
            if (stalled)
                chk("stall_hold", cd == hd && cbe == hbe && cl == hl,
                    {27'd0, cl, cbe, cd}, {27'd0, hl, hbe, hd});
            rdy = (cyc < 16) ? v.mask[cyc[3:0]] : 1'b1;
            tx_ready = rdy;
            abort = (k == v.abort_w);
            if (!cv) begin
                chk("valid_held", 1'b0, 64'd0, 64'd1);
            end else if (rdy) begin
                ed  = v.first + v.inc * 32'(k);
                el  = (k == nt - 1);
                ebe = el ? v.lbe : 4'b1111;
                chk("word", cd == ed && cbe == ebe && cl == el && cep == v.ep,
                    {24'd0, cep, cl, cbe, cd}, {24'd0, v.ep, el, ebe, ed});
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; hd = cd; hbe = cbe; hl = cl;
            end
            @(negedge fifoClk);
            cyc++;
        end
        tx_ready = 1'b0; abort = 1'b0;
        if (cyc >= 200) chk("timeout", 1'b0, 64'(k), 64'(v.n));
        cv = v.sel ? v2 : v1; cdn = v.sel ? dn2 : dn1; cab = v.sel ? ab2 : ab1; cb = v.sel ? b2 : b1;
        chk("fin", cdn && cab == v.exp_ab && !cv && !cb,
            {60'd0, cdn, cab, cv, cb}, {60'd0, 1'b1, v.exp_ab, 2'b00});
        @(negedge fifoClk);
        cdn = v.sel ? dn2 : dn1; cb = v.sel ? b2 : b1;
        chk("done_pulse", !cdn && !cb, {62'd0, cdn, cb}, 64'd0);
    endtask

    task automatic err_chk(input logic [2:0] e, input logic [15:0] l);
        start = 1'b1; ep_sel = e; pkt_len = l;
        @(negedge fifoClk);
        start = 1'b0;
        chk("err_pulse", e1 && !v1 && !b1, {61'd0, e1, v1, b1}, 64'd4);
        @(negedge fifoClk);
        chk("err_clear", !e1 && !v1 && !b1, {61'd0, e1, v1, b1}, 64'd0);
    endtask

    initial begin
        //            ep    len    clr   mask      abw sel first         inc           n  lbe    ab
        tbl[0]  = '{3'd1, 16'd16, 1'b0, 16'hFFFF, -1, 1'b0, 32'd0,        32'd1,        4, 4'hF, 1'b0};
        tbl[1]  = '{3'd1, 16'd6,  1'b0, 16'hFFFF, -1, 1'b0, 32'd4,        32'd1,        2, 4'h3, 1'b0};
        tbl[2]  = '{3'd2, 16'd4,  1'b0, 16'hFFFF, -1, 1'b0, 32'd0,        32'd1,        1, 4'hF, 1'b0};
        tbl[3]  = '{3'd3, 16'd12, 1'b0, 16'hFFE9, -1, 1'b0, 32'd0,        32'd1,        3, 4'hF, 1'b0};
        tbl[4]  = '{3'd4, 16'd40, 1'b0, 16'hFFFB,  2, 1'b0, 32'd0,        32'd1,        3, 4'hF, 1'b1};
        tbl[5]  = '{3'd4, 16'd4,  1'b0, 16'hFFFF, -1, 1'b0, 32'd3,        32'd1,        1, 4'hF, 1'b0};
        tbl[6]  = '{3'd1, 16'd7,  1'b0, 16'hFFFF, -1, 1'b0, 32'd6,        32'd1,        2, 4'h7, 1'b0};
        tbl[7]  = '{3'd2, 16'd5,  1'b0, 16'hFFFF, -1, 1'b0, 32'd1,        32'd1,        2, 4'h1, 1'b0};
        tbl[8]  = '{3'd1, 16'd12, 1'b1, 16'hFFFF, -1, 1'b1, 32'd0,        32'h7FFFFFFF, 3, 4'hF, 1'b0};
        tbl[9]  = '{3'd1, 16'd12, 1'b0, 16'hFFFF, -1, 1'b1, 32'h7FFFFFFD, 32'h7FFFFFFF, 3, 4'hF, 1'b0};
        tbl[10] = '{3'd1, 16'd8,  1'b1, 16'hFFFF, -1, 1'b0, 32'd0,        32'd1,        2, 4'hF, 1'b0};

        fifoRst = 1'b1; start = 1'b0; abort = 1'b0; clr_seq = 1'b0; tx_ready = 1'b0;
        ep_sel = 3'd0; pkt_len = 16'd0;
        @(negedge fifoClk);
        @(negedge fifoClk);
        chk("reset_outputs", {v1, d1, be1, l1, ep1, b1, dn1, ab1, e1} == '0,
            {19'd0, v1, d1, be1, l1, ep1, b1, dn1, ab1, e1}, 64'd0);
        fifoRst = 1'b0;
        @(negedge fifoClk);
        chk("idle_after_reset", !v1 && !b1 && !dn1, {61'd0, v1, b1, dn1}, 64'd0);

        for (int i = 0; i < 11; i++) run(tbl[i]);

        err_chk(3'd1, 16'd0);
        err_chk(3'd0, 16'd8);
        err_chk(3'd5, 16'd8);

        start = 1'b1; ep_sel = 3'd1; pkt_len = 16'd40; tx_ready = 1'b1;
        @(negedge fifoClk);
        start = 1'b0;
        @(negedge fifoClk);
        chk("mid_pkt_valid", v1, {63'd0, v1}, 64'd1);
        @(negedge fifoClk);
        fifoRst = 1'b1;
        #1;
        chk("mid_pkt_reset", {v1, d1, be1, l1, ep1, b1, dn1, ab1} == '0,
            {20'd0, v1, d1, be1, l1, ep1, b1, dn1, ab1}, 64'd0);
        @(negedge fifoClk);
        fifoRst = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge fifoClk);
            chk("no_done_after_reset", !dn1 && !b1 && !v1, {61'd0, dn1, b1, v1}, 64'd0);
        end
        run('{3'd1, 16'd4, 1'b0, 16'hFFFF, -1, 1'b0, 32'd0, 32'd1, 1, 4'hF, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stream_src_gen.md
Name: stream_src_gen

Overview:
- Data-stream source that sits directly upstream of the FT600 FIFO master's endpoint buffers in stream mode (i_mode=1).
- Produces fixed-length packets of incrementing 32-bit words on a valid/ready interface, tagged with the target endpoint number (001..100).
- The endpoint buffer write side accepts the words; the FIFO master then drains them to USB.
- Keeps an independent running sequence counter per endpoint so the host can check stream continuity across packets.

Parameters:
- LEN_W, 16, width of packet length in bytes
- SEED_INC, 1, value added to the endpoint sequence counter per accepted word

Ports:
- fifoClk  input  1  FIFO clock, all logic rising-edge
- fifoRst  input  1  asynchronous active-high reset
- start  input  1  single-cycle packet request, sampled in IDLE only
- ep_sel  input  3  target endpoint, valid values 3'b001..3'b100, sampled with start
- pkt_len  input  LEN_W  packet length in bytes, sampled with start
- abort  input  1  terminate current packet after any pending word handshake
- clr_seq  input  1  zero all four sequence counters (honoured in IDLE only)
- tx_ready  input  1  endpoint buffer accepts the word (not full)
- tx_valid  output  1  word present
- tx_data  output  32  payload word
- tx_be  output  4  byte enables, bit0 = byte0
- tx_last  output  1  final word of packet
- tx_ep_num  output  3  endpoint tag, stable for the whole packet
- busy  output  1  high from LOAD through SEND
- done  output  1  one-cycle pulse at packet end (normal or aborted)
- aborted  output  1  qualifies done; high when the packet was cut short
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async assert, sync release to fifoClk): every output is 0, FSM is IDLE, and the four sequence counters are 0.
- FSM states: IDLE, LOAD, SEND, FIN.
- IDLE, start=1:
  - If pkt_len=0 or ep_sel is not in 001..100, pulse err the next cycle and remain in IDLE.
  - Otherwise latch ep_sel and pkt_len, then go to LOAD.
- LOAD (one cycle):
  - words_left = ceil(pkt_len/4), computed as (pkt_len+3)>>2 at LEN_W+1 bits so 16'hFFFF does not overflow.
  - last_be from pkt_len[1:0]: 00->1111, 01->0001, 10->0011, 11->0111.
  - Load the working word from seq[ep]. Go to SEND.
  - busy is high from LOAD onward.
- SEND:
  - tx_valid=1. tx_data = working word. tx_ep_num = latched ep.
  - words_left=1: tx_last=1 and tx_be=last_be. Otherwise tx_last=0 and tx_be=1111.
  - Handshake = tx_valid & tx_ready. On a handshake: working word += SEED_INC (mod 2^32, wraps 32'hFFFFFFFF->0); seq[ep] is updated with the same value; words_left decrements.
  - While tx_valid=1 and tx_ready=0, tx_data, tx_be, tx_last and tx_ep_num hold stable. tx_valid is never withdrawn without a handshake.
- Leaving SEND:
  - Handshake with tx_last=1: go to FIN, aborted=0.
  - abort=1 and tx_ready=1 in the same cycle: the word completes normally, then go to FIN with aborted=1 (unless it was the last word, in which case aborted=0).
  - abort=1 while stalled (tx_ready=0): it is registered and applied at the next handshake.
- FIN (one cycle):
  - done=1, aborted as determined in SEND, tx_valid=0, busy=0. Then go to IDLE.
  - start in FIN is ignored.
- Latency: start accepted in cycle N gives tx_valid=1 in cycle N+2. With tx_ready held at 1, throughput is one word per cycle.
- seq[ep] persists across packets. After an aborted packet, seq[ep] = last accepted word + SEED_INC, so the next packet continues seamlessly.
- clr_seq:
  - In IDLE, clr_seq zeroes all four counters.
  - If clr_seq and a valid start occur in the same cycle, the clear applies first and the packet starts from 0.
  - Outside IDLE, clr_seq is ignored.
- start, ep_sel and pkt_len changes outside IDLE have no effect.
- Reset mid-packet: all outputs drop to 0 immediately and no done pulse is generated.

Test Plan:
- Reset, then start with ep_sel=001, pkt_len=16, tx_ready=1 -> tx_valid in cycle N+2; 4 words 0,1,2,3; tx_be=1111 on all; tx_last on word 3; done=1 and aborted=0 one cycle after the last handshake.
- Then start with ep_sel=001, pkt_len=6 -> words 4,5; last tx_be=0011. Then start with ep_sel=010, pkt_len=4 -> single word 0, proving per-endpoint counters are independent.
- Start with ep_sel=011, pkt_len=12, tx_ready toggling 1,0,0,1,0,1 -> exactly 3 handshakes; data 0,1,2 each held stable across every stall cycle.
- Start with ep_sel=100, pkt_len=40; assert abort while stalled at the 3rd word, then raise tx_ready -> 3 words 0,1,2 sent; done=1 with aborted=1. The next 4-byte packet on ep 100 carries word 3.
- Start with pkt_len=0, and separately ep_sel=000 and ep_sel=101 -> err pulse each time, tx_valid stays 0, busy stays 0.
- Preload seq[1]=32'hFFFFFFFE via 32'hFFFFFFFE prior words (or force), then pkt_len=12 -> data FFFFFFFE, FFFFFFFF, 00000000. Then clr_seq plus start -> packet begins at 0. Assert fifoRst mid-packet -> outputs 0 immediately, no done pulse.
